// File: rtl/m_memarb_if.sv
// m_memarb_if: requester, memory and counter-readout signals of the round-robin memory arbiter.
interface m_memarb_if #(
  parameter int N_REQ = 3,
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic                mem_we;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_dout;
  logic [1:0]          cnt_sel;
  logic                cnt_clr;
  logic [CW-1:0]       cnt;
  modport master (
    output req, we, addr, din, mem_dout, cnt_sel, cnt_clr,
    input  gnt, rvalid, rdata, mem_addr, mem_we, mem_din, cnt
  );
  modport slave (
    input  req, we, addr, din, mem_dout, cnt_sel, cnt_clr,
    output gnt, rvalid, rdata, mem_addr, mem_we, mem_din, cnt
  );
endinterface

// File: rtl/m_memarb.sv
// m_memarb: round-robin arbiter sharing one single-port 1-cycle-read memory among N_REQ requesters,
// with saturating per-requester grant counters.
module m_memarb #(
  parameter int N_REQ = 3,
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  m_memarb_if.slave  bus
);
  logic [1:0]    ptr;
  logic [1:0]    idx;
  logic [1:0]    c;
  logic          found;
  logic [CW-1:0] cnt_q [N_REQ];
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = 2'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
  // grant is suppressed during reset so a write presented then never reaches the memory
  assign bus.gnt = (found && rst_n) ? N_REQ'(1) << idx : '0;
  assign bus.mem_addr = bus.addr[idx*AW +: AW];
  assign bus.mem_din = bus.din[idx*DW +: DW];
  assign bus.mem_we = |bus.gnt & bus.we[idx];
  assign bus.rdata = bus.mem_dout;
  assign bus.cnt = (int'(bus.cnt_sel) < N_REQ) ? cnt_q[bus.cnt_sel] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= 2'(N_REQ - 1);
      bus.rvalid <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      if (found) ptr <= idx;
      bus.rvalid <= bus.mem_we ? '0 : bus.gnt;
      for (int i = 0; i < N_REQ; i++)
        cnt_q[i] <= bus.cnt_clr ? '0 : (bus.gnt[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
endmodule

// File: tb/tb_m_memarb.sv
// tb_m_memarb: directed stimulus with a read-return scoreboard and a behavioural 1-cycle memory.
module tb_m_memarb;
  localparam int N = 3, AW = 12, DW = 32, CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {logic [N-1:0] v; logic [DW-1:0] d;} exp_t;
  exp_t q[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] mem [4096];
  m_memarb_if #(.N_REQ(N), .AW(AW), .DW(DW), .CW(CW)) bus ();
  m_memarb #(.N_REQ(N), .AW(AW), .DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = r;
    bus.we[i] = w;
    bus.addr[i*AW +: AW] = a;
    bus.din[i*DW +: DW] = d;
  endtask
  task automatic idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask
  // one cycle: score the previous return, check this cycle's grant, push the expected read return
  task automatic step(input logic [N-1:0] eg);
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid", bus.rvalid, e.v);
      if (e.v != 0) chk("rdata", bus.rdata, e.d);
    end else chk("rvalid_idle", bus.rvalid, '0);
    chk("gnt", bus.gnt, eg);
    chk("mem_we", bus.mem_we, |(eg & bus.we));
    for (int i = 0; i < N; i++)
      if (eg[i]) begin
        chk("mem_addr", bus.mem_addr, bus.addr[i*AW +: AW]);
        if (bus.we[i]) begin
          chk("mem_din", bus.mem_din, bus.din[i*DW +: DW]);
          ref_mem[int'(bus.addr[i*AW +: AW])] = bus.din[i*DW +: DW];
        end else begin
          e.v = N'(1) << i;
          e.d = ref_mem[int'(bus.addr[i*AW +: AW])];
          q.push_back(e);
        end
      end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input logic [1:0] s, input int e);
    bus.cnt_sel = s;
    #1;
    chk($sformatf("cnt%0d", s), bus.cnt, e);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    set_req(0, 1'b1, 1'b1, 12'd5, 32'hBAD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_rvalid", bus.rvalid, '0);
    for (int s = 0; s < N; s++) chk_cnt(2'(s), 0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    idle();
    bus.cnt_sel = '0;
    bus.cnt_clr = 1'b0;
    do_reset();
    // preload through the debug loader
    set_req(2, 1'b1, 1'b1, 12'd5, 32'h2A);         step(3'b100);
    set_req(2, 1'b1, 1'b1, 12'd10, 32'h1111_0010); step(3'b100);
    set_req(2, 1'b1, 1'b1, 12'd11, 32'h2222_0011); step(3'b100);
    set_req(2, 1'b1, 1'b1, 12'd12, 32'h3333_0012); step(3'b100);
    idle();
    step(3'b000);
    do_reset();
    // single read, data one cycle after grant
    set_req(0, 1'b1, 1'b0, 12'd5, '0); step(3'b001);
    idle();
    step(3'b000);
    // all requesting: strict rotation
    do_reset();
    set_req(0, 1'b1, 1'b0, 12'd10, '0);
    set_req(1, 1'b1, 1'b0, 12'd11, '0);
    set_req(2, 1'b1, 1'b0, 12'd12, '0);
    for (int r = 0; r < 2; r++) begin
      step(3'b001); step(3'b010); step(3'b100);
    end
    idle();
    step(3'b000);
    for (int s = 0; s < N; s++) chk_cnt(2'(s), 2);
    chk_cnt(2'd3, 0);
    // read after write on consecutive grants
    set_req(0, 1'b1, 1'b1, 12'd7, 32'hDEAD); step(3'b001);
    idle();
    set_req(1, 1'b1, 1'b0, 12'd7, '0);       step(3'b010);
    idle();
    step(3'b000);
    // req1 held while req0 re-requests every cycle
    set_req(0, 1'b1, 1'b0, 12'd10, '0);
    set_req(1, 1'b1, 1'b0, 12'd11, '0);
    for (int r = 0; r < 2; r++) begin
      step(3'b001); step(3'b010);
    end
    idle();
    step(3'b000);
    // counter saturation and clear priority
    bus.cnt_clr = 1'b1; step(3'b000);
    bus.cnt_clr = 1'b0;
    chk_cnt(2'd2, 0);
    set_req(2, 1'b1, 1'b0, 12'd12, '0);
    for (int r = 0; r < 20; r++) begin
      step(3'b100);
      if (r == 14) chk_cnt(2'd2, 15);
    end
    chk_cnt(2'd2, 15);
    bus.cnt_clr = 1'b1; step(3'b100);
    bus.cnt_clr = 1'b0;
    chk_cnt(2'd2, 0);
    idle();
    step(3'b000);
    chk_cnt(2'd2, 0);
    // reset with a read return pending, and a write presented during reset
    set_req(0, 1'b1, 1'b0, 12'd10, '0); step(3'b001);
    chk("rv_pre", bus.rvalid, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rv_async", bus.rvalid, '0);
    q.delete();
    set_req(0, 1'b1, 1'b1, 12'd5, 32'hBAD);
    @(negedge clk);
    chk("rst_gnt2", bus.gnt, '0);
    chk("rst_we2", bus.mem_we, 1'b0);
    for (int s = 0; s < N; s++) chk_cnt(2'(s), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 12'd5, '0);
    set_req(1, 1'b1, 1'b0, 12'd11, '0);
    set_req(2, 1'b1, 1'b0, 12'd12, '0);
    step(3'b001); step(3'b010); step(3'b100);
    idle();
    step(3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
